// File: rtl/id00001006_pkg.sv
// Shared types and constants for the I/Q sink.
// No logic; compile-time only.
// Imported by the buffer and the top level.
package id00001006_pkg;

  // Default width of one I or Q sample.
  localparam int DATAPATH_WIDTH_DEF = 32;

  // Width of the delivered-pair counter and of the programmed target.
  localparam int CNT_W = 16;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pack one pair into the {Q, I} word layout used throughout the block.
  function automatic logic [2*DATAPATH_WIDTH_DEF-1:0] pack_iq(
    input logic [DATAPATH_WIDTH_DEF-1:0] i_smp,
    input logic [DATAPATH_WIDTH_DEF-1:0] q_smp
  );
    return {q_smp, i_smp};
  endfunction

endpackage

// File: rtl/id00001006_iq_sink_buf.sv
// Circular I/Q pair buffer with first-word fall-through read.
// Latency: a pushed pair is visible on rd_dat one cycle after the push edge.
// Backpressure: afull decoded from registered occupancy; writes into a full buffer are dropped and flagged sticky.
module id00001006_iq_sink_buf
  import id00001006_pkg::*;
#(
  parameter int DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
  parameter int ADDR_WIDTH     = 3,
  parameter int AF_DIFF        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        wr_vld,
  input  logic [2*DATAPATH_WIDTH-1:0] wr_dat,
  output logic                        afull,
  output logic                        overflow,
  output logic                        rd_vld,
  input  logic                        rd_rdy,
  output logic [2*DATAPATH_WIDTH-1:0] rd_dat,
  output logic                        pop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int OCC_W = ADDR_WIDTH + 1;

  logic [2*DATAPATH_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0]       wr_ptr;
  logic [ADDR_WIDTH-1:0]       rd_ptr;
  logic [OCC_W-1:0]            occ;
  logic [OCC_W-1:0]            free_slots;
  logic                        full;
  logic                        push;
  logic                        wr_drop;

  // Status decode and handshake qualification, all from registered occupancy.
  // A pop never frees a slot for a push in the same cycle: full blocks the push outright.
  always_comb begin
    full       = (occ == OCC_W'(DEPTH));
    rd_vld     = (occ != '0);
    push       = wr_vld && !full;
    wr_drop    = wr_vld && full;
    pop        = rd_vld && rd_rdy;
    free_slots = OCC_W'(DEPTH) - occ;
    afull      = (free_slots <= OCC_W'(AF_DIFF));
    rd_dat     = mem[rd_ptr];
  end

  // Storage: zeroed on reset only; a flush leaves stale contents in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !clear) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Sticky overflow: any write strobe that met a full buffer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/id00001006_iq_sink.sv
// Receive endpoint for interpolated I/Q pairs: buffers pairs and counts deliveries against a target.
// Latency: push to rd_valid_o is 1 cycle; done_o follows the final counted pop by 1 cycle.
// Backpressure: Afull_o to the core when free slots <= AF_DIFF; reader stalls via rd_ready_i.
module id00001006_iq_sink
  import id00001006_pkg::*;
#(
  parameter int DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
  parameter int ADDR_WIDTH     = 3,
  parameter int AF_DIFF        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            sample_target_i,
  input  logic                        Write_Enable_i,
  input  logic [DATAPATH_WIDTH-1:0]   I_interp_i,
  input  logic [DATAPATH_WIDTH-1:0]   Q_interp_i,
  output logic                        Afull_o,
  output logic                        rd_valid_o,
  input  logic                        rd_ready_i,
  output logic [2*DATAPATH_WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overflow_o
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] target;
  logic             pop;
  logic             count_en;
  logic             hit;
  logic             done_set;
  logic             done_q;

  id00001006_iq_sink_buf #(
    .DATAPATH_WIDTH (DATAPATH_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .AF_DIFF        (AF_DIFF)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_i),
    .wr_vld   (Write_Enable_i),
    .wr_dat   ({Q_interp_i, I_interp_i}),
    .afull    (Afull_o),
    .overflow (overflow_o),
    .rd_vld   (rd_valid_o),
    .rd_rdy   (rd_ready_i),
    .rd_dat   (rd_data_o),
    .pop      (pop)
  );

  // Pop qualification for the counter: only in RUN, and never in a clear or restart cycle.
  always_comb begin
    count_inc = count + 1'b1;
    count_en  = !clear_i && !start_i && (state == RUN) && pop;
    hit       = (count_inc == target);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: clear beats start, start beats the counted pop; a zero target never enters RUN.
  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = IDLE;
    end else if (start_i) begin
      state_nxt = (sample_target_i != '0) ? RUN : IDLE;
    end else begin
      case (state)
        RUN:     if (count_en && hit) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Outputs decoded from state; done_set marks the edge of the final counted pop.
  always_comb begin
    busy_o   = (state == RUN);
    done_set = count_en && hit;
    count_o  = count;
    done_o   = done_q;
  end

  // Counter, target latch and one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count  <= '0;
      target <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_set;
      if (start_i) begin
        count  <= '0;
        target <= sample_target_i;
      end else if (count_en) begin
        count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_id00001006_iq_sink.sv
module tb_id00001006_iq_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_i;
  logic        start_i;
  logic [15:0] sample_target_i;
  logic        Write_Enable_i;
  logic [31:0] I_interp_i;
  logic [31:0] Q_interp_i;
  logic        Afull_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [63:0] rd_data_o;
  logic [15:0] count_o;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of pairs plus run-control bookkeeping.
  logic [63:0] mq[$];
  bit          m_ovf;
  int          m_cnt;
  int          m_tgt;
  int          m_st;    // 0 idle, 1 run, 2 done
  bit          m_done;

  id00001006_iq_sink dut (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (clear_i),
    .start_i         (start_i),
    .sample_target_i (sample_target_i),
    .Write_Enable_i  (Write_Enable_i),
    .I_interp_i      (I_interp_i),
    .Q_interp_i      (Q_interp_i),
    .Afull_o         (Afull_o),
    .rd_valid_o      (rd_valid_o),
    .rd_ready_i      (rd_ready_i),
    .rd_data_o       (rd_data_o),
    .count_o         (count_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_valid", rd_valid_o, mq.size() != 0);
    if (mq.size() != 0) chk("rd_data", rd_data_o, mq[0]);
    chk("afull", Afull_o, (8 - mq.size()) <= 2);
    chk("count", count_o, m_cnt);
    chk("busy", busy_o, m_st == 1);
    chk("done", done_o, m_done);
    chk("overflow", overflow_o, m_ovf);
  endtask

  task automatic do_reset();
    rst = 1'b1; clear_i = 1'b0; start_i = 1'b0; sample_target_i = '0;
    Write_Enable_i = 1'b0; I_interp_i = '0; Q_interp_i = '0; rd_ready_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    mq.delete(); m_ovf = 0; m_cnt = 0; m_tgt = 0; m_st = 0; m_done = 0;
    chk("rst_data", rd_data_o, 64'd0);
    check_all();
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit we, input bit rdy, input bit st, input bit clr,
                      input logic [15:0] tgt, input logic [31:0] i_s, input logic [31:0] q_s);
    bit pop_m, push_m, drop_m;
    Write_Enable_i = we; rd_ready_i = rdy; start_i = st; clear_i = clr;
    sample_target_i = tgt; I_interp_i = i_s; Q_interp_i = q_s;
    pop_m  = (mq.size() > 0) && rdy;
    push_m = we && (mq.size() < 8);
    drop_m = we && (mq.size() == 8);
    m_done = 0;
    if (clr) begin
      mq.delete(); m_ovf = 0; m_st = 0; m_cnt = 0;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back({q_s, i_s});
      if (drop_m) m_ovf = 1;
      if (st) begin
        m_tgt = tgt; m_cnt = 0; m_st = (tgt != 0) ? 1 : 0;
      end else if (m_st == 1 && pop_m) begin
        m_cnt++;
        if (m_cnt == m_tgt) begin m_st = 2; m_done = 1; end
      end
    end
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    do_reset();

    // Target 4, four pairs with reader always ready.
    step(0, 1, 1, 0, 16'd4, 0, 0);
    for (int k = 1; k <= 4; k++) step(1, 1, 0, 0, 0, k, 32'h100 + k - 1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 0);
    chk("t1_count", count_o, 64'd4);
    chk("t1_busy", busy_o, 64'd0);

    // Fill to full with reader stalled, then one write too many.
    for (int k = 0; k < 9; k++) step(1, 0, 0, 0, 0, 32'h200 + k, 32'h300 + k);
    chk("t2_ovf", overflow_o, 64'd1);
    chk("t2_afull", Afull_o, 64'd1);

    // Full with simultaneous push and pop: pop wins, push dropped.
    step(1, 1, 0, 0, 0, 32'hdead, 32'hbeef);
    chk("t3_afull_occ7", Afull_o, 64'd1);

    // Drain and stream enough to wrap the pointers.
    for (int k = 0; k < 12; k++) step(k < 10, 1, 0, 0, 0, 32'h400 + k, 32'h500 + k);
    for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0, 0, 0);
    chk("t4_empty", rd_valid_o, 64'd0);

    // Clear mid-run with count 3 and occupancy 5.
    step(0, 0, 1, 0, 16'd10, 0, 0);
    for (int k = 0; k < 8; k++) step(1, k >= 5, 0, 0, 0, 32'h600 + k, 32'h700 + k);
    chk("t5_count3", count_o, 64'd3);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t5_clr_busy", busy_o, 64'd0);
    chk("t5_clr_valid", rd_valid_o, 64'd0);
    step(0, 0, 1, 0, 16'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t5_zero_tgt_busy", busy_o, 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0,
             16'($urandom_range(1, 12)), $urandom, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id00001006_iq_sink.md
# id00001006_iq_sink

Receive-side endpoint for the interpolator's output stream. It accepts interpolated I/Q pairs under the Write_Enable / almost-full protocol the core drives. Pairs are buffered in a small circular buffer and handed to a downstream reader over a valid/ready handshake. Delivered pairs are counted against a programmed target, with a done pulse when the target is reached; the block sits between the interpolator core's output and the capture/DMA logic.

## Interface
- DATAPATH_WIDTH, 32, width of each I and Q sample
- ADDR_WIDTH, 3, buffer address bits; DEPTH = 2**ADDR_WIDTH = 8
- AF_DIFF, 2, Afull_o asserts when free slots <= AF_DIFF
- clk  in  1  single clock, posedge
- rst  in  1  synchronous reset, active-high
- clear_i  in  1  sync flush of buffer, count, overflow and state
- start_i  in  1  one-cycle pulse: load sample_target_i, zero count, enter RUN
- sample_target_i  in  16  pairs to deliver before done
- Write_Enable_i  in  1  core write strobe; one I/Q pair per high cycle
- I_interp_i  in  DATAPATH_WIDTH  interpolated I sample
- Q_interp_i  in  DATAPATH_WIDTH  interpolated Q sample
- Afull_o  out  1  almost-full back-pressure to the core
- rd_valid_o  out  1  buffer non-empty
- rd_ready_i  in  1  reader accepts head pair
- rd_data_o  out  2*DATAPATH_WIDTH  head pair, {Q, I}
- count_o  out  16  pairs delivered in current run
- busy_o  out  1  state == RUN
- done_o  out  1  one-cycle pulse on target reached
- overflow_o  out  1  sticky: write arrived while full

## Operation
- Buffer: DEPTH-entry register array; wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap DEPTH-1 -> 0; occupancy is ADDR_WIDTH+1 bits.
- Push: Write_Enable_i && occupancy < DEPTH. Write_Enable_i with occupancy == DEPTH: data dropped, no pointer/occupancy change, overflow_o set.
- Pop: rd_valid_o && rd_ready_i; rd_data_o = mem[rd_ptr] (first-word fall-through).
- Full plus simultaneous push and pop: pop is taken, push is rejected as overflow. A pop does not free a slot in the same cycle.
- Empty plus simultaneous push and rd_ready_i: push only. rd_valid_o is low, so no pop.
- Push and pop in the same cycle otherwise: occupancy unchanged.
- Afull_o = (DEPTH - occupancy) <= AF_DIFF, decoded from the occupancy register.
- The buffer operates in every state. Only pops are counted.
- FSM states:
  - IDLE: after reset or clear_i. start_i with target != 0 moves to RUN with count 0. start_i with target == 0 stays in IDLE.
  - RUN: each pop increments count. The pop that makes count == target moves to DONE and sets done_o the next cycle.
  - DONE: count holds and further pops are not counted. start_i restarts exactly as from IDLE.
- start_i in RUN: restart by reloading target, zeroing count, staying in RUN. A pop in the same cycle is not counted.
- Priority: rst > clear_i > start_i > push/pop bookkeeping.
- clear_i does not clear memory contents, only pointers and occupancy.

## Timing
- Reset values: Afull_o 0, rd_valid_o 0, rd_data_o 0 (memory reset to 0), count_o 0, busy_o 0, done_o 0, overflow_o 0, state IDLE.
- Push at edge k: rd_valid_o high and rd_data_o valid after edge k, so latency is 1 cycle.
- Afull_o updates 1 cycle after the push that crosses the threshold. AF_DIFF = 2 covers one in-flight core write after Afull_o rises.
- done_o is high for exactly the one cycle after the edge where the final counted pop occurred; busy_o drops in that same cycle.
- rst or clear_i mid-run: all outputs return to reset values on the next edge, except rd_data_o after clear_i, which shows the stale mem[0].

## Structure
- Package id00001006_pkg holds the DATAPATH_WIDTH default, the state enum (IDLE, RUN, DONE) and the 16-bit count width constant.
- Sub-module id00001006_iq_sink_buf contains the circular buffer: pointers, occupancy, Afull_o, overflow detection and FWFT read. Count and FSM stay in the top level.

## Test plan
- start_i with target=4, then push 4 pairs I=1..4, Q=0x100..0x103 with rd_ready_i=1 -> rd_data_o sequence {0x100,1}..{0x103,4}, count_o 1..4, one done_o pulse, busy_o falls.
- rd_ready_i=0, push 6 pairs -> Afull_o rises after the 6th push (occupancy 6). Push 2 more -> occupancy 8. 9th push -> overflow_o=1 and occupancy stays 8.
- Full buffer, push and pop same cycle -> 1 pair popped, push dropped, overflow_o=1, occupancy 7.
- Empty buffer, push with rd_ready_i=1 -> no pop that cycle; the pair is popped next cycle.
- Pop 10 pairs with wr_ptr/rd_ptr wrapping past 7 -> data in order, no loss.
- clear_i mid-RUN with count 3 and occupancy 5 -> next cycle count 0, rd_valid_o 0, busy_o 0, overflow_o 0. start_i with target 0 -> stays IDLE with no done_o.
